// File: rtl/lieat_clint_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : lieat_clint_bridge
//  Purpose  : Memory-mapped initiator between the LSU peripheral port and the
//             CLINT register interface. Decodes the CLINT window, performs a
//             one-cycle access (read-merge-write for stores), and returns the
//             result over a valid/ready response channel.
//  Revision : 1.0 - initial release
//
//  Build option:
//    LIEAT_CLINT_BRIDGE_PIPE_EN - when defined, a new request may be accepted
//                                 in the same cycle the response is consumed
//                                 (RESP -> ACCESS directly, 1 access / 2 cycles).
//                                 When undefined, requests are taken in IDLE
//                                 only (1 access / 3 cycles).
//
//  Ports:
//    clock, reset            core clock; asynchronous active-high reset
//    req_valid/req_ready     request handshake
//    req_addr/wen/wdata/wmask request fields (wmask used for stores only)
//    rsp_valid/rsp_ready     response handshake
//    rsp_rdata/rsp_err       load data (0 for stores/faults), access fault
//    clint_timeset_*         timer register select/strobe/data/readback
//    clint_msipset_*         msip strobe/data/readback
// ============================================================================
module lieat_clint_bridge #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter int          XLEN       = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic            req_wen,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_wmask,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            clint_timeset_wen,
    output logic [1:0]      clint_timeset_bsel,
    output logic [XLEN-1:0] clint_timeset_wdata,
    input  logic [XLEN-1:0] clint_timeset_rdata,
    output logic            clint_msipset_wen,
    output logic [XLEN-1:0] clint_msipset_wdata,
    input  logic [XLEN-1:0] clint_msipset_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------------
    // Address decode of the incoming request
    // ------------------------------------------------------------------------
    logic [31:0] offset;
    logic        dec_msip;
    logic        dec_tmr;
    logic [1:0]  dec_bsel;
    logic        dec_err;

    assign offset = req_addr - CLINT_BASE;

    always_comb begin
        dec_msip = 1'b0;
        dec_tmr  = 1'b0;
        dec_bsel = 2'b00;
        case (offset)
            32'h0000_0000: dec_msip = 1'b1;
            32'h0000_4000: begin dec_tmr = 1'b1; dec_bsel = 2'b00; end
            32'h0000_4004: begin dec_tmr = 1'b1; dec_bsel = 2'b01; end
            32'h0000_BFF8: begin dec_tmr = 1'b1; dec_bsel = 2'b10; end
            32'h0000_BFFC: begin dec_tmr = 1'b1; dec_bsel = 2'b11; end
            default: ;
        endcase
    end

    // mtime (bsel[1]=1) is read-only from this port; an empty strobe set is
    // treated as a malformed store.
    assign dec_err = (req_addr[1:0] != 2'b00)
                   || !(dec_msip || dec_tmr)
                   || (req_wen && dec_tmr && dec_bsel[1])
                   || (req_wen && (req_wmask == 4'b0000));

    // ------------------------------------------------------------------------
    // Latched request
    // ------------------------------------------------------------------------
    logic            is_msip_q;
    logic [1:0]      bsel_q;
    logic            err_q;
    logic            wen_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wmask_q;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            accept;

    // ------------------------------------------------------------------------
    // Access-cycle data path
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] sel_rdata;
    logic [XLEN-1:0] bytemask;
    logic [XLEN-1:0] merged;
    logic            legal_store;
    logic            legal_load;

    assign sel_rdata   = is_msip_q ? clint_msipset_rdata : clint_timeset_rdata;
    assign bytemask    = {{8{wmask_q[3]}}, {8{wmask_q[2]}},
                          {8{wmask_q[1]}}, {8{wmask_q[0]}}};
    assign merged      = (sel_rdata & ~bytemask) | (wdata_q & bytemask);
    assign legal_store = !err_q && wen_q;
    assign legal_load  = !err_q && !wen_q;

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d             = state_q;
        accept              = 1'b0;
        req_ready           = 1'b0;
        rsp_valid           = 1'b0;
        rsp_rdata_d         = rsp_rdata_q;
        rsp_err_d           = rsp_err_q;
        clint_timeset_wen   = 1'b0;
        clint_timeset_bsel  = 2'b00;
        clint_timeset_wdata = '0;
        clint_msipset_wen   = 1'b0;
        clint_msipset_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Select is driven only here, so CLINT readback is sampled in
                // this single cycle and later changes cannot affect the result.
                clint_timeset_bsel = bsel_q;
                if (legal_store) begin
                    if (is_msip_q) begin
                        clint_msipset_wen   = 1'b1;
                        clint_msipset_wdata = {{(XLEN-1){1'b0}}, merged[0]};
                    end else begin
                        clint_timeset_wen   = 1'b1;
                        clint_timeset_wdata = merged;
                    end
                end
                rsp_rdata_d = legal_load ? sel_rdata : '0;
                rsp_err_d   = err_q;
                state_d     = ST_RESP;
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
`ifdef LIEAT_CLINT_BRIDGE_PIPE_EN
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    if (req_valid) begin
                        accept  = 1'b1;
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`else
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            is_msip_q   <= 1'b0;
            bsel_q      <= 2'b00;
            err_q       <= 1'b0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= 4'b0000;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                is_msip_q <= dec_msip;
                bsel_q    <= dec_bsel;
                err_q     <= dec_err;
                wen_q     <= req_wen;
                wdata_q   <= req_wdata;
                wmask_q   <= req_wmask;
            end
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lieat_clint_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lieat_clint_bridge
//  Purpose  : Self-checking bench for lieat_clint_bridge. A simple CLINT
//             register file model answers the bridge; a reference memory map
//             computed from the address-map rules predicts every response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lieat_clint_bridge;

    localparam logic [31:0] C_BASE = 32'h0200_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        clint_timeset_wen;
    logic [1:0]  clint_timeset_bsel;
    logic [31:0] clint_timeset_wdata;
    logic [31:0] clint_timeset_rdata;
    logic        clint_msipset_wen;
    logic [31:0] clint_msipset_wdata;
    logic [31:0] clint_msipset_rdata;

    always #5 clock = ~clock;

    lieat_clint_bridge dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_addr            (req_addr),
        .req_wen             (req_wen),
        .req_wdata           (req_wdata),
        .req_wmask           (req_wmask),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_rdata           (rsp_rdata),
        .rsp_err             (rsp_err),
        .clint_timeset_wen   (clint_timeset_wen),
        .clint_timeset_bsel  (clint_timeset_bsel),
        .clint_timeset_wdata (clint_timeset_wdata),
        .clint_timeset_rdata (clint_timeset_rdata),
        .clint_msipset_wen   (clint_msipset_wen),
        .clint_msipset_wdata (clint_msipset_wdata),
        .clint_msipset_rdata (clint_msipset_rdata)
    );

    // CLINT register file: mtimecmp lo/hi, mtime lo/hi, plus msip.
    logic [31:0] ctim [4] = '{32'h1111_0000, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0000_0001};
    logic [31:0] cmsip = 32'h0;
    int          tw_cnt = 0;
    int          mw_cnt = 0;

    assign clint_timeset_rdata = ctim[clint_timeset_bsel];
    assign clint_msipset_rdata = cmsip;

    always @(posedge clock) begin
        if (clint_timeset_wen) begin
            ctim[clint_timeset_bsel] <= clint_timeset_wdata;
            tw_cnt <= tw_cnt + 1;
        end
        if (clint_msipset_wen) begin
            cmsip  <= clint_msipset_wdata;
            mw_cnt <= mw_cnt + 1;
        end
    end

    // Reference map: index 0..3 = timer regs by bsel, 4 = msip.
    logic [31:0] mdl [5];
    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] a, input logic w, input logic [3:0] wm,
                                       output int idx, output bit e);
        logic [31:0] off;
        off = a - C_BASE;
        case (off)
            32'h0000: idx = 4;
            32'h4000: idx = 0;
            32'h4004: idx = 1;
            32'hBFF8: idx = 2;
            32'hBFFC: idx = 3;
            default:  idx = -1;
        endcase
        e = (a % 4 != 0) || (idx < 0) || (w && (idx == 2 || idx == 3)) || (w && wm == 4'h0);
    endfunction

    // One complete transaction, non-overlapped, with an optional response stall.
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] wm, input int stall);
        int idx; bit e;
        logic [31:0] cur, bm, merged, exp_rd;
        int t0, m0;
        ref_decode(a, w, wm, idx, e);
        cur = (idx >= 0) ? mdl[idx] : 32'h0;
        bm = 32'h0;
        for (int b = 0; b < 4; b++) if (wm[b]) bm[b*8 +: 8] = 8'hFF;
        merged = (cur & ~bm) | (wd & bm);
        exp_rd = (!e && !w) ? cur : 32'h0;
        t0 = tw_cnt; m0 = mw_cnt;

        @(negedge clock);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = wd; req_wmask = wm;
        rsp_ready = 1'b0;
        @(negedge clock);                       // access cycle
        req_valid = 1'b0;
        chk("ts_wen", {31'b0, clint_timeset_wen}, {31'b0, (!e && w && idx < 4)});
        chk("msip_wen", {31'b0, clint_msipset_wen}, {31'b0, (!e && w && idx == 4)});
        if (!e && idx >= 0 && idx < 4) chk("bsel", {30'b0, clint_timeset_bsel}, idx);
        if (!e && w && idx < 4) chk("ts_wdata", clint_timeset_wdata, merged);
        if (!e && w && idx == 4) chk("msip_wdata", clint_msipset_wdata, {31'b0, merged[0]});
        @(negedge clock);                       // response cycle
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e});
        if (stall > 0) begin
            req_valid = 1'b1; req_addr = C_BASE + 32'hBFF8; req_wen = 1'b0;
            for (int i = 0; i < stall; i++) begin
                chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
                @(negedge clock);
                chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
                chk("stall_rsp_rdata", rsp_rdata, exp_rd);
                chk("stall_rsp_err", {31'b0, rsp_err}, {31'b0, e});
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_done", {31'b0, rsp_valid}, 32'd0);
        chk("idle_bsel", {30'b0, clint_timeset_bsel}, 32'd0);
        chk("idle_wdata", clint_timeset_wdata | clint_msipset_wdata, 32'd0);
        chk("ts_wen_count", tw_cnt - t0, (!e && w && idx < 4) ? 1 : 0);
        chk("msip_wen_count", mw_cnt - m0, (!e && w && idx == 4) ? 1 : 0);
        if (!e && w) mdl[idx] = (idx == 4) ? {31'b0, merged[0]} : merged;
    endtask

    logic [31:0] offs [9] = '{32'h0000, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC,
                              32'h8000, 32'h4002, 32'h0001, 32'hC000};

    initial begin
        int t0, m0;
        mdl[0] = 32'h1111_0000; mdl[1] = 32'hFFFF_FFFF;
        mdl[2] = 32'h0000_1234; mdl[3] = 32'h0000_0001; mdl[4] = 32'h0;

        // Reset state
        @(negedge clock);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_wen", {30'b0, clint_timeset_wen, clint_msipset_wen}, 32'd0);
        chk("rst_bsel", {30'b0, clint_timeset_bsel}, 32'd0);
        chk("rst_wdata", clint_timeset_wdata | clint_msipset_wdata, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        reset = 1'b0;

        // Directed cases
        txn(C_BASE + 32'hBFF8, 1'b0, 32'h0, 4'h0, 0);          // mtime lo load
        txn(C_BASE + 32'h4004, 1'b1, 32'hAABB_CCDD, 4'b0011, 0);// mtimecmp hi merge
        chk("mtimecmp_hi_val", ctim[1], 32'hFFFF_CCDD);
        txn(C_BASE + 32'h0000, 1'b1, 32'h0000_0003, 4'hF, 0);  // msip store
        chk("msip_val", cmsip, 32'h0000_0001);
        txn(C_BASE + 32'hBFFC, 1'b1, 32'h1234_5678, 4'hF, 0);  // store to mtime: fault
        txn(C_BASE + 32'h4002, 1'b0, 32'h0, 4'h0, 0);          // misaligned
        txn(C_BASE + 32'h8000, 1'b0, 32'h0, 4'h0, 0);          // unmapped
        txn(C_BASE + 32'h4000, 1'b1, 32'hDEAD_BEEF, 4'h0, 0);  // empty strobes
        txn(C_BASE + 32'h4004, 1'b0, 32'h0, 4'h0, 5);          // stalled response

        // Reset asserted during the access cycle of a legal store
        @(negedge clock);
        req_valid = 1'b1; req_addr = C_BASE + 32'h4000; req_wen = 1'b1;
        req_wdata = 32'h5555_5555; req_wmask = 4'hF;
        @(posedge clock);
        t0 = tw_cnt; m0 = mw_cnt;
        #1 reset = 1'b1;
        #1;
        chk("midrst_wen", {31'b0, clint_timeset_wen}, 32'd0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clock);
        req_valid = 1'b0; reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end
        chk("postrst_ts_wen_count", tw_cnt - t0, 32'd0);
        chk("postrst_msip_wen_count", mw_cnt - m0, 32'd0);

`ifdef LIEAT_CLINT_BRIDGE_PIPE_EN
        // Back-to-back loads: second accepted on the response handshake.
        @(negedge clock);
        req_valid = 1'b1; req_addr = C_BASE + 32'hBFF8; req_wen = 1'b0; req_wmask = 4'h0;
        @(negedge clock);
        req_addr = C_BASE + 32'h4000; rsp_ready = 1'b1;
        @(negedge clock);
        chk("pipe_rsp1_valid", {31'b0, rsp_valid}, 32'd1);
        chk("pipe_rsp1_rdata", rsp_rdata, mdl[2]);
        chk("pipe_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        chk("pipe_access2_valid", {31'b0, rsp_valid}, 32'd0);
        chk("pipe_access2_bsel", {30'b0, clint_timeset_bsel}, 32'd0);
        @(negedge clock);
        chk("pipe_rsp2_valid", {31'b0, rsp_valid}, 32'd1);
        chk("pipe_rsp2_rdata", rsp_rdata, mdl[0]);
        @(negedge clock);
        rsp_ready = 1'b0;
`endif

        // Randomized traffic against the reference map
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = C_BASE + offs[$urandom_range(0, 8)];
            txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 4; k++) chk("final_timer_reg", ctim[k], mdl[k]);
        chk("final_msip", cmsip, mdl[4]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lieat_clint_bridge.md
Name: lieat_clint_bridge

Overview:
- Memory-mapped initiator that turns core LSU load/store requests into accesses on the CLINT register interface.
- Decodes the CLINT address window and drives the timeset and msipset write-enable, select and data signals.
- Samples CLINT read data, merges partial-width stores, and returns a response over a valid/ready channel.
- Sits between the LSU peripheral port and the CLINT timer/software-interrupt block.

Parameters:
- CLINT_BASE, 32'h0200_0000, base of the CLINT window; all offsets below are relative to it.
- XLEN, 32, data width; fixed at 32 for this block.

Ports:
- clock  in  1  core clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  bridge can accept a request
- req_addr  in  32  byte address
- req_wen  in  1  1=store, 0=load
- req_wdata  in  32  store data
- req_wmask  in  4  byte strobes; used for stores only
- rsp_valid  out  1  response valid
- rsp_ready  in  1  LSU accepts the response
- rsp_rdata  out  32  load data; 0 for stores and on error
- rsp_err  out  1  access fault
- clint_timeset_wen  out  1  write strobe to the timer registers
- clint_timeset_bsel  out  2  timer register select: 00 mtimecmp lo, 01 mtimecmp hi, 10 mtime lo, 11 mtime hi
- clint_timeset_wdata  out  32  timer write data
- clint_timeset_rdata  in  32  timer read data; combinational from bsel
- clint_msipset_wen  out  1  msip write strobe
- clint_msipset_wdata  out  32  msip write data
- clint_msipset_rdata  in  32  msip read data

Behaviour:
- Decode on offset = req_addr - CLINT_BASE:
  - 0x0000 -> msip
  - 0x4000 -> bsel 00
  - 0x4004 -> bsel 01
  - 0xBFF8 -> bsel 10
  - 0xBFFC -> bsel 11
  - any other offset -> unmapped
- Fault conditions (rsp_err=1):
  - req_addr[1:0] != 0 (misaligned);
  - unmapped offset;
  - store to mtime lo/hi (mtime is read-only through this port);
  - store with req_wmask == 0.
- A faulting request still completes through the FSM, but never asserts any wen, and returns rsp_rdata=0.
- FSM states: IDLE, ACCESS, RESP. Transitions:
  - IDLE: req_ready=1. On req_valid, latch addr, wen, wdata, wmask and the decode result, then go to ACCESS.
  - ACCESS, one cycle:
    - drive bsel from the latched decode;
    - merged = (rdata & bytemask(wmask)) | (wdata & ~... ) — precisely: merged = (rdata & ~bytemask(wmask)) | (wdata & bytemask(wmask)), where rdata is the rdata of the selected register;
    - for a legal store: pulse the selected wen for exactly this cycle with merged;
    - msip store data is {31'b0, merged[0]};
    - for a legal load: capture rdata into the response register;
    - go to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready. When rsp_ready=1, go to IDLE.
- Latency and throughput:
  - request accepted in cycle N; wen pulses in N+1; rsp_valid rises in N+2;
  - one outstanding request at a time; base throughput is 1 per 3 cycles.
- Output defaults outside ACCESS: wen=0, bsel=00, wdata=0.
- Reset, asynchronous, may occur mid-operation:
  - state -> IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - both wen=0, bsel=00, both wdata=0;
  - req_ready=1 after reset;
  - an in-flight request is dropped with no response and no wen pulse.
- Because the select is driven only in ACCESS, CLINT rdata changing between cycles has no effect on the result.

Optional Feature:
- Macro LIEAT_CLINT_BRIDGE_PIPE_EN.
- Defined: in RESP, req_ready = rsp_ready.
  - A request presented in the same cycle the response is consumed is latched, and the FSM goes directly RESP->ACCESS.
  - Throughput becomes 1 per 2 cycles.
- Undefined: req_ready=1 only in IDLE; the RESP->IDLE->ACCESS path is always taken.

Test Plan:
- Load 0x0200_BFF8 with CLINT rdata for bsel 10 = 32'h0000_1234, rsp_ready=1:
  - bsel=10 in N+1; rsp_valid in N+2; rsp_rdata=32'h0000_1234; rsp_err=0; no wen.
- Store 0x0200_4004, wdata 32'hAABB_CCDD, wmask 4'b0011, with CLINT mtimecmp hi = 32'hFFFF_FFFF:
  - clint_timeset_wen high for exactly one cycle; bsel=01; wdata=32'hFFFF_CCDD.
- Store 0x0200_0000, wdata 32'h0000_0003, wmask 4'hF:
  - clint_msipset_wen for one cycle; wdata=32'h0000_0001.
- Faults, each -> rsp_err=1, rsp_rdata=0, no wen asserted:
  - store to 0x0200_BFFC;
  - load from 0x0200_4002;
  - load from 0x0200_8000.
- rsp_ready held 0 for 5 cycles after rsp_valid:
  - rsp_valid/rdata stable throughout; req_ready=0; a second req_valid is not accepted until the response is consumed.
- Assert reset during ACCESS of a legal store:
  - no wen pulse is observed after reset; rsp_valid=0; req_ready=1 after reset.
- With PIPE_EN defined, back-to-back loads:
  - second request accepted in the cycle the first response handshakes; its rsp_valid follows 2 cycles later.
